// File: rtl/rx_cicf_fir_if.sv
// rtl/rx_cicf_fir_if.sv - sample, coefficient and status signals of the CIC-compensation FIR
interface rx_cicf_fir_if #(
   parameter int WIDTH      = 24,
   parameter int COEF_WIDTH = 18,
   parameter int NTAPS      = 32
);
   localparam int AW = $clog2(NTAPS);

   logic                         in_strobe;
   logic signed [WIDTH-1:0]      in_data_i;
   logic signed [WIDTH-1:0]      in_data_q;
   logic                         coef_wr;
   logic [AW-1:0]                coef_addr;
   logic signed [COEF_WIDTH-1:0] coef_data;
   logic                         out_strobe;
   logic signed [WIDTH-1:0]      out_data_i;
   logic signed [WIDTH-1:0]      out_data_q;
   logic                         busy;
   logic                         overrun;

   modport master (
      output in_strobe, in_data_i, in_data_q, coef_wr, coef_addr, coef_data,
      input  out_strobe, out_data_i, out_data_q, busy, overrun
   );

   modport slave (
      input  in_strobe, in_data_i, in_data_q, coef_wr, coef_addr, coef_data,
      output out_strobe, out_data_i, out_data_q, busy, overrun
   );
endinterface

// File: rtl/rx_cicf_fir.sv
// rtl/rx_cicf_fir.sv - time-multiplexed I/Q CIC-compensation FIR, one multiplier per channel
module rx_cicf_fir #(
   parameter int WIDTH      = 24,
   parameter int COEF_WIDTH = 18,
   parameter int NTAPS      = 32
) (
   input logic          adc_clk,
   input logic          reset,
   rx_cicf_fir_if.slave bus
);
   localparam int AW   = $clog2(NTAPS);
   localparam int FW   = $clog2(NTAPS + 1);
   localparam int KW   = $clog2(NTAPS + 2);
   localparam int PW   = WIDTH + COEF_WIDTH;
   localparam int ACCW = PW + $clog2(NTAPS);
   localparam int SH   = COEF_WIDTH - 2;

   typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

   state_t                       state_q, state_d;
   logic signed [COEF_WIDTH-1:0] coef_mem [NTAPS];
   logic signed [WIDTH-1:0]      hist_i [NTAPS];
   logic signed [WIDTH-1:0]      hist_q [NTAPS];

   logic [AW-1:0]                wptr_q, wptr_d, base_q, base_d;
   logic [FW-1:0]                fill_q, fill_d;
   logic [KW-1:0]                k_q, k_d;
   logic signed [COEF_WIDTH-1:0] c_q, c_d;
   logic signed [WIDTH-1:0]      xi_q, xi_d, xq_q, xq_d;
   logic signed [PW-1:0]         pi_q, pi_d, pq_q, pq_d;
   logic signed [ACCW-1:0]       acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic signed [WIDTH-1:0]      out_i_q, out_i_d, out_q_q, out_q_d;
   logic                         overrun_q, overrun_d;
   logic                         accept, tap_live;
   logic [AW-1:0]                rd_idx;
   int                           idx_int;

   function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [ACCW-1:0] a);
      logic signed [ACCW:0] r;
      r = ($signed({a[ACCW-1], a}) + (ACCW+1)'(2 ** (SH - 1))) >>> SH;
      if (r[ACCW:WIDTH-1] == '0 || r[ACCW:WIDTH-1] == '1)
         round_sat = r[WIDTH-1:0];
      else
         round_sat = r[ACCW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   assign accept = bus.in_strobe && (state_q == IDLE);

   // Tap k reads x[n-k]; taps beyond the fill count feed zeros so stale history is never used.
   always_comb begin
      idx_int  = 0;
      rd_idx   = '0;
      tap_live = 1'b0;
      if (int'(k_q) < NTAPS) begin
         idx_int = int'(base_q) - int'(k_q);
         if (idx_int < 0) idx_int = idx_int + NTAPS;
         rd_idx   = AW'(idx_int);
         tap_live = int'(k_q) < int'(fill_q);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_strobe) state_d = MAC;
         MAC:     if (int'(k_q) == NTAPS + 1) state_d = ROUND;
         ROUND:   state_d = OUT;
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wptr_d    = wptr_q;
      base_d    = base_q;
      fill_d    = fill_q;
      k_d       = k_q;
      c_d       = '0;
      xi_d      = '0;
      xq_d      = '0;
      pi_d      = PW'(c_q) * PW'(xi_q);
      pq_d      = PW'(c_q) * PW'(xq_q);
      acc_i_d   = acc_i_q;
      acc_q_d   = acc_q_q;
      out_i_d   = out_i_q;
      out_q_d   = out_q_q;
      overrun_d = overrun_q | (bus.in_strobe & (state_q != IDLE));
      unique case (state_q)
         IDLE: if (accept) begin
            base_d  = wptr_q;
            wptr_d  = (int'(wptr_q) == NTAPS - 1) ? '0 : wptr_q + 1'b1;
            if (int'(fill_q) < NTAPS) fill_d = fill_q + 1'b1;
            k_d     = '0;
            acc_i_d = '0;
            acc_q_d = '0;
         end
         MAC: begin
            if (tap_live) begin
               c_d  = coef_mem[AW'(k_q)];
               xi_d = hist_i[rd_idx];
               xq_d = hist_q[rd_idx];
            end
            k_d     = k_q + 1'b1;
            acc_i_d = acc_i_q + ACCW'(pi_q);
            acc_q_d = acc_q_q + ACCW'(pq_q);
         end
         ROUND: begin
            out_i_d = round_sat(acc_i_q);
            out_q_d = round_sat(acc_q_q);
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.out_strobe = (state_q == OUT);
      bus.busy       = (state_q != IDLE);
      bus.out_data_i = out_i_q;
      bus.out_data_q = out_q_q;
      bus.overrun    = overrun_q;
   end

   always_ff @(posedge adc_clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         wptr_q    <= '0;
         base_q    <= '0;
         fill_q    <= '0;
         k_q       <= '0;
         c_q       <= '0;
         xi_q      <= '0;
         xq_q      <= '0;
         pi_q      <= '0;
         pq_q      <= '0;
         acc_i_q   <= '0;
         acc_q_q   <= '0;
         out_i_q   <= '0;
         out_q_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         base_q    <= base_d;
         fill_q    <= fill_d;
         k_q       <= k_d;
         c_q       <= c_d;
         xi_q      <= xi_d;
         xq_q      <= xq_d;
         pi_q      <= pi_d;
         pq_q      <= pq_d;
         acc_i_q   <= acc_i_d;
         acc_q_q   <= acc_q_d;
         out_i_q   <= out_i_d;
         out_q_q   <= out_q_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge adc_clk) begin
      if (bus.coef_wr && int'(bus.coef_addr) < NTAPS)
         coef_mem[bus.coef_addr] <= bus.coef_data;
      if (accept) begin
         hist_i[wptr_q] <= bus.in_data_i;
         hist_q[wptr_q] <= bus.in_data_q;
      end
   end
endmodule

// File: tb/tb_rx_cicf_fir.sv
// tb/tb_rx_cicf_fir.sv - table-driven scoreboard bench for rx_cicf_fir
module tb_rx_cicf_fir;
   localparam int WIDTH      = 24;
   localparam int COEF_WIDTH = 18;
   localparam int NTAPS      = 32;
   localparam int AW         = $clog2(NTAPS);
   localparam int LAT        = NTAPS + 4;

   typedef struct {
      int                      t;
      logic signed [WIDTH-1:0] ei;
      logic signed [WIDTH-1:0] eq;
   } exp_t;

   typedef struct {
      int                      mode;
      bit                      rst;
      logic signed [WIDTH-1:0] in_i;
      logic signed [WIDTH-1:0] in_q;
      logic signed [WIDTH-1:0] exp_i;
      logic signed [WIDTH-1:0] exp_q;
   } vec_t;

   logic   adc_clk = 1'b0;
   logic   reset;
   int     cyc = 0;
   int     n_cmp = 0;
   int     n_err = 0;
   exp_t   sb[$];
   vec_t   vecs[$];

   rx_cicf_fir_if #(.WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .NTAPS(NTAPS)) bus ();

   rx_cicf_fir #(.WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .NTAPS(NTAPS)) dut (
      .adc_clk (adc_clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 adc_clk = ~adc_clk;
   always @(posedge adc_clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic observe();
      exp_t e;
      if (bus.out_strobe === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_out_strobe", longint'(bus.out_strobe), 0);
         end else begin
            e = sb.pop_front();
            check("out_i", bus.out_data_i, e.ei);
            check("out_q", bus.out_data_q, e.eq);
            check("latency", cyc - e.t, LAT);
         end
      end
   endtask

   task automatic tick();
      @(negedge adc_clk);
      observe();
      @(posedge adc_clk);
      #1;
   endtask

   function automatic int coef_val(input int mode, input int k);
      case (mode)
         0:       coef_val = ((k + 1) * 4096 > 131071) ? 131071 : (k + 1) * 4096;
         1:       coef_val = 65536;
         2:       coef_val = (k == 0) ? 32768 : 0;
         default: coef_val = 131071;
      endcase
   endfunction

   function automatic vec_t mk(input int mode, input bit rst, input int ii, input int iq,
                               input int ei, input int eq);
      vec_t v;
      v.mode  = mode;
      v.rst   = rst;
      v.in_i  = WIDTH'(ii);
      v.in_q  = WIDTH'(iq);
      v.exp_i = WIDTH'(ei);
      v.exp_q = WIDTH'(eq);
      return v;
   endfunction

   task automatic load_coefs(input int mode);
      for (int k = 0; k < NTAPS; k++) begin
         bus.coef_wr   = 1'b1;
         bus.coef_addr = AW'(k);
         bus.coef_data = COEF_WIDTH'(coef_val(mode, k));
         tick();
      end
      bus.coef_wr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic drive(input logic signed [WIDTH-1:0] i, input logic signed [WIDTH-1:0] q);
      bus.in_strobe = 1'b1;
      bus.in_data_i = i;
      bus.in_data_q = q;
   endtask

   task automatic send(input logic signed [WIDTH-1:0] i, input logic signed [WIDTH-1:0] q,
                       input logic signed [WIDTH-1:0] ei, input logic signed [WIDTH-1:0] eq);
      drive(i, q);
      sb.push_back('{cyc, ei, eq});
      tick();
      bus.in_strobe = 1'b0;
      repeat (LAT) tick();
      check("drain", sb.size(), 0);
   endtask

   initial begin
      int cur_mode;
      reset         = 1'b1;
      bus.in_strobe = 1'b0;
      bus.in_data_i = '0;
      bus.in_data_q = '0;
      bus.coef_wr   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;

      // Tap 31 of the ramp cannot hold 32*4096, so the impulse run stops at output 30.
      for (int n = 0; n < 31; n++)
         vecs.push_back(mk(0, n == 0, (n == 0) ? 16000 : 0, (n == 0) ? -16000 : 0,
                           1000 * (n + 1), -1000 * (n + 1)));
      for (int n = 0; n < 40; n++)
         vecs.push_back(mk(1, n == 0, 100, 0, 100 * ((n + 1 > NTAPS) ? NTAPS : n + 1), 0));
      vecs.push_back(mk(2, 1'b1, 3, -3, 2, -1));
      vecs.push_back(mk(2, 1'b0, -3, 3, -1, 2));
      vecs.push_back(mk(3, 1'b1, 8388607, -8388608, 8388607, -8388608));
      vecs.push_back(mk(3, 1'b1, -8388608, 8388607, -8388608, 8388607));

      @(posedge adc_clk);
      #1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rst_out_strobe", bus.out_strobe, 0);
      check("rst_out_i", bus.out_data_i, 0);
      check("rst_out_q", bus.out_data_q, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_overrun", bus.overrun, 0);

      cur_mode = -1;
      foreach (vecs[idx]) begin
         if (vecs[idx].mode != cur_mode) begin
            load_coefs(vecs[idx].mode);
            cur_mode = vecs[idx].mode;
         end
         if (vecs[idx].rst) do_reset();
         send(vecs[idx].in_i, vecs[idx].in_q, vecs[idx].exp_i, vecs[idx].exp_q);
      end

      // Handshake: busy window, single pulse, held output.
      load_coefs(1);
      do_reset();
      drive(7, -7);
      sb.push_back('{cyc, 24'sd7, -24'sd7});
      for (int d = 1; d <= LAT + 2; d++) begin
         tick();
         if (d == 1) bus.in_strobe = 1'b0;
         check("busy_window", bus.busy, (d <= LAT) ? 1 : 0);
      end
      check("drain", sb.size(), 0);
      repeat (5) tick();
      check("hold_i", bus.out_data_i, 7);
      check("hold_q", bus.out_data_q, -7);

      // Overrun: second strobe at t+5 dropped, strobe at t+37 accepted.
      drive(10, -10);
      sb.push_back('{cyc, 24'sd17, -24'sd17});
      tick();
      bus.in_strobe = 1'b0;
      repeat (4) tick();
      drive(999, -999);
      tick();
      bus.in_strobe = 1'b0;
      check("overrun_set", bus.overrun, 1);
      repeat (31) tick();
      check("drain", sb.size(), 0);
      drive(20, -20);
      sb.push_back('{cyc, 24'sd37, -24'sd37});
      tick();
      bus.in_strobe = 1'b0;
      repeat (LAT) tick();
      check("drain", sb.size(), 0);
      check("overrun_sticky", bus.overrun, 1);

      // Reset in the middle of MAC aborts the sample and clears everything.
      drive(50, -50);
      tick();
      bus.in_strobe = 1'b0;
      repeat (9) tick();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("abort_out_i", bus.out_data_i, 0);
      check("abort_out_q", bus.out_data_q, 0);
      check("abort_overrun", bus.overrun, 0);
      check("abort_busy", bus.busy, 0);
      repeat (LAT + 4) tick();
      send(500, -500, 500, -500);
      send(1, -1, 501, -501);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
